// File: rtl/shift_enc_pkg.sv
// shift_enc_pkg: shared FSM states, mode constants and key-byte helper for the shift encoder.
package shift_enc_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;
  localparam int MAX_KEY_W = 256;
  // Byte 0 is the most significant byte (lowest indices of the ascending vector).
  function automatic logic [7:0] key_byte(input logic [0:MAX_KEY_W-1] key, input int i);
    return key[8*i +: 8];
  endfunction
endpackage

// File: rtl/shift_enc_round.sv
// shift_enc_round: one combinational keyed rotate/xor round; decode path built only with SHIFT_ENC_DECODE_EN.
module shift_enc_round
  import shift_enc_pkg::*;
#(
  parameter int DATA_W = 80
) (
  input  logic [0:DATA_W-1] st_i,
  input  logic [7:0]        kb_i,
  input  logic              mode_i,
  output logic [0:DATA_W-1] st_o
);
  localparam int RB = (DATA_W + 7) / 8;
  logic [31:0] s;
  logic [0:8*RB-1] rep;
  logic [0:DATA_W-1] m, enc;
  assign s = 32'(kb_i) % 32'(DATA_W);
  assign rep = {RB{kb_i}};
  assign m = rep[8*RB-DATA_W:8*RB-1];
  assign enc = ((st_i << s) | (st_i >> (32'(DATA_W) - s))) ^ m;
`ifdef SHIFT_ENC_DECODE_EN
  logic [0:DATA_W-1] t, dec;
  assign t = st_i ^ m;
  assign dec = (t >> s) | (t << (32'(DATA_W) - s));
  assign st_o = mode_i == MODE_DEC ? dec : enc;
`else
  logic unused_mode;
  assign unused_mode = mode_i;
  assign st_o = enc;
`endif
endmodule

// File: rtl/shift_encoder_seq.sv
// shift_encoder_seq: handshaked multi-round keyed shift encoder, one round per clock.
// Define SHIFT_ENC_DECODE_EN to honour the mode port and build the decode datapath.
module shift_encoder_seq
  import shift_enc_pkg::*;
#(
  parameter int DATA_W = 80,
  parameter int KEY_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:DATA_W-1] data_in,
  input  logic [0:KEY_W-1]  final_key,
  input  logic              mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:DATA_W-1] data_out
);
  localparam int ROUNDS = KEY_W / 8;
  localparam int CW = ROUNDS > 1 ? $clog2(ROUNDS) : 1;
  logic [1:0] state_q, state_d;
  logic [0:DATA_W-1] data_q, data_d, round_st;
  logic [0:KEY_W-1] key_q, key_d;
  logic mode_q, mode_d, mode_eff;
  logic [CW-1:0] cnt_q, cnt_d, ri;
  logic [0:MAX_KEY_W-1] key_ext;
  logic [7:0] kb;
`ifdef SHIFT_ENC_DECODE_EN
  assign mode_eff = mode;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign mode_eff = MODE_ENC;
`endif
  always_comb begin
    key_ext = '0;
    key_ext[0:KEY_W-1] = key_q;
  end
  // Decode walks the key bytes backwards using the same up-counter.
  assign ri = mode_q == MODE_DEC ? CW'(ROUNDS - 1) - cnt_q : cnt_q;
  assign kb = key_byte(key_ext, int'(ri));
  shift_enc_round #(.DATA_W(DATA_W)) u_round (
    .st_i  (data_q),
    .kb_i  (kb),
    .mode_i(mode_q),
    .st_o  (round_st)
  );
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    key_d = key_q;
    mode_d = mode_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && in_valid) begin
      state_d = RUN;
      data_d = data_in;
      key_d = final_key;
      mode_d = mode_eff;
      cnt_d = '0;
    end
    if (state_q == RUN) begin
      data_d = round_st;
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == CW'(ROUNDS - 1) ? DONE : RUN;
    end
    if (state_q == DONE && out_ready) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q <= '0;
      key_q <= '0;
      mode_q <= MODE_ENC;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      key_q <= key_d;
      mode_q <= mode_d;
      cnt_q <= cnt_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign data_out = data_q;
endmodule

// File: tb/tb_shift_encoder_seq.sv
// tb_shift_encoder_seq: scoreboard bench for shift_encoder_seq with directed vectors.
module tb_shift_encoder_seq;
  localparam int ROUNDS = 8;
  typedef struct {
    logic [79:0] exp;
    int          acc;
  } item_t;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, mode, out_valid, out_ready;
  logic [0:79] data_in, data_out;
  logic [0:63] final_key;
  item_t sb[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit seen = 1'b0;
  shift_encoder_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .final_key(final_key), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [79:0] model(input logic [79:0] d, input logic [63:0] k, input bit dec);
    logic [79:0] x, m;
    logic [159:0] w;
    logic [7:0] b;
    int s;
    x = d;
    for (int j = 0; j < ROUNDS; j++) begin
      int i = dec ? ROUNDS - 1 - j : j;
      b = k[63-8*i -: 8];
      s = int'(b) % 80;
      m = {10{b}};
      if (!dec) begin
        w = {x, x} << s;
        x = w[159:80] ^ m;
      end else begin
        w = {x ^ m, x ^ m} >> s;
        x = w[79:0];
      end
    end
    return x;
  endfunction
  task automatic send(input logic [79:0] d, input logic [63:0] k, input bit m, input logic [79:0] exp);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_ready", 80'(in_ready), 80'd1);
    in_valid = 1'b1;
    data_in = d;
    final_key = k;
    mode = m;
    sb.push_back('{exp, cyc + 1});
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in = ~d;
    final_key = ~k;
    mode = ~m;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", 80'(sb.size()), 80'd0);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !seen) begin
        seen = 1'b1;
        if (sb.size() == 0) chk("spurious_out", 80'(out_valid), 80'd0);
        else chk("latency", 80'(cyc - sb[0].acc), 80'(ROUNDS));
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        chk("data", data_out, sb[0].exp);
        void'(sb.pop_front());
        seen = 1'b0;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [79:0] x, y, z;
    logic [63:0] k;
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    mode = 1'b0;
    data_in = '0;
    final_key = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 80'(in_ready), 80'd1);
    chk("rst_out_valid", 80'(out_valid), 80'd0);
    chk("rst_data_out", data_out, 80'd0);
    send(80'h78554abc478acbdef789, 64'h0, 1'b0, 80'h78554abc478acbdef789);
    send(80'h1, 64'h0100000000000000, 1'b0, 80'h01010101010101010103);
    send(80'h0, 64'h5000000000000000, 1'b0, 80'h50505050505050505050);
    send(80'h80000000000000000000, 64'h0100000000000000, 1'b0, 80'h01010101010101010100);
    send(80'h1, 64'h4f00000000000000, 1'b0, 80'hcf4f4f4f4f4f4f4f4f4f);
    x = 80'h78554abc478acbdef789;
    k = 64'h0102030405060708;
    y = model(x, k, 1'b0);
`ifdef SHIFT_ENC_DECODE_EN
    z = x;
`else
    z = model(y, k, 1'b0);
`endif
    send(x, k, 1'b0, y);
    send(y, k, 1'b1, z);
    drain();
    out_ready = 1'b0;
    send(80'h1, 64'h0100000000000000, 1'b0, 80'h01010101010101010103);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_valid", 80'(out_valid), 80'd1);
    repeat (20) begin
      @(negedge clk);
      chk("bp_data", data_out, 80'h01010101010101010103);
      chk("bp_in_ready", 80'(in_ready), 80'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk("bp_idle_ready", 80'(in_ready), 80'd1);
    chk("bp_idle_valid", 80'(out_valid), 80'd0);
    out_ready = 1'b1;
    drain();
    send(80'h123456789abcdef01234, 64'h0102030405060708, 1'b0, 80'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    chk("mid_rst_in_ready", 80'(in_ready), 80'd1);
    chk("mid_rst_out_valid", 80'(out_valid), 80'd0);
    chk("mid_rst_data_out", data_out, 80'd0);
    send(80'h1, 64'h0100000000000000, 1'b0, 80'h01010101010101010103);
    drain();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/shift_encoder_seq.md
# shift_encoder_seq

Multi-round, handshaked successor to the combinational shift encoder. It is parametrised in data and key width, and processes one keyed round per clock with an encode/decode mode. It sits between the ballot/data packer and the storage/transmit path. It accepts one word per transaction on a valid/ready input and presents the result on a valid/ready output.

## Interface
- `DATA_W`, default 80: data word width in bits; must be ≥ 8.
- `KEY_W`, default 64: key width in bits; must be a multiple of 8.
- `ROUNDS` (localparam) = KEY_W/8: one round per key byte.
- `clk` in, 1 bit: clock; all logic is on the rising edge.
- `rst` in, 1 bit: reset, synchronous and active-high.
- `in_valid` in, 1 bit: `data_in`, `final_key` and `mode` are valid.
- `in_ready` out, 1 bit: the block can accept a word.
- `data_in` in, `[0:DATA_W-1]`: plaintext (encode) or ciphertext (decode).
- `final_key` in, `[0:KEY_W-1]`: key; byte i = `final_key[8i:8i+7]`, so byte 0 is the MSB byte.
- `mode` in, 1 bit: 0 = encode, 1 = decode.
- `out_valid` out, 1 bit: `data_out` holds a result.
- `out_ready` in, 1 bit: the consumer takes the result.
- `data_out` out, `[0:DATA_W-1]`: result, held stable while `out_valid` is high.

## Operation
- Definitions:
  - k_i = key byte i.
  - s_i = k_i mod DATA_W (rotate amount).
  - m_i = k_i replicated across DATA_W bits, truncated to the low DATA_W bits.
  - rotl and rotr are circular rotations over the DATA_W-bit word.
- Encode applies rounds i = 0 … ROUNDS-1 in order: `st ← rotl(st, s_i) ^ m_i`.
- Decode applies rounds i = ROUNDS-1 … 0 in order: `st ← rotr(st ^ m_i, s_i)`. Decode is the exact inverse of encode.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, latch `data_in` into the state register, and latch `final_key` and `mode`. Clear the round counter and go to RUN.
  - RUN: apply one round per cycle. After the round with counter = ROUNDS-1, go to DONE.
  - DONE: `out_valid`=1 and `data_out` = state register. On `out_ready`, go to IDLE.
- Inputs are sampled only at the accept edge. Changes to `data_in`, `final_key` or `mode` after that edge have no effect on the transaction in flight.
- `in_ready`=0 in RUN and DONE. A DONE-to-IDLE transition and a new accept never occur in the same cycle.
- Reset values:
  - FSM = IDLE.
  - `in_ready`=1 from the first cycle after reset.
  - `out_valid`=0.
  - `data_out`=0, the state register is also cleared.
  - Round counter = 0.
- Reset mid-RUN or mid-DONE abandons the transaction. No output is produced for it.

## Timing
- Accept edge T0. Rounds execute at edges T1 … T_ROUNDS. `out_valid` rises after edge T_ROUNDS, giving a latency of ROUNDS cycles (8 by default).
- Throughput: one word per ROUNDS+2 cycles when `out_ready` is held high.
- `out_valid` stays high and `data_out` is frozen until `out_ready` is sampled high. Back-pressure has no bound.
- `in_ready` and `out_valid` are registered-state decodes; there are no combinational paths from input to output.

## Configuration
- `SHIFT_ENC_DECODE_EN` defined: the `mode` port is honoured, and both encode and decode datapaths are built.
- Not defined: `mode` is ignored and treated as 0. Only the encode datapath is synthesised. The port list is unchanged.

## Structure
- Shared package `shift_enc_pkg`:
  - FSM state enum (IDLE, RUN, DONE).
  - Mode constants `MODE_ENC` and `MODE_DEC`.
  - Function `key_byte(key, i)`.
- One natural sub-module, `shift_enc_round`: a combinational single round.
  - Inputs: state, key byte, mode.
  - Output: next state.
  - Instantiated once and driven by the round counter.

## Test plan
- `final_key`=0 and `data_in`=80'h78554abc478acbdef789, encode → `data_out`=80'h78554abc478acbdef789 after exactly 8 cycles.
- `final_key`=64'h0100000000000000 and `data_in`=80'h1, encode → `data_out`=80'h01010101010101010103.
- `final_key`=64'h5000000000000000 and `data_in`=0, encode → 80'h50505050505050505050. Checks that a rotate of 80 mod 80 = 0.
- Round trip with `final_key`=64'h0102030405060708: encode 80'h78554abc478acbdef789, then decode the result with the same key → original word (`SHIFT_ENC_DECODE_EN` defined).
- Back-pressure: hold `out_ready`=0 for 20 cycles after `out_valid` rises → `data_out` stable, `in_ready`=0 throughout. Pulse `out_ready` → IDLE on the next cycle.
- Assert `rst` at the fourth RUN cycle → the next cycle shows IDLE, `out_valid`=0 and `data_out`=0. A fresh transaction then completes with a correct result.
